message_loc_reader: RTL and testbench

MESSAGE_LOC_READER -- requirements
Module: message_loc_reader

---
 rtl/message_loc_reader.sv | 133 +++++++++++++
 tb/tb_message_loc_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/message_loc_reader.sv
// Streams stored messages out byte by byte. Each message's start and end
// buffer addresses come from a location table indexed by the read index.
module message_loc_reader #(
  parameter int DATA_WIDTH  = 5,
  parameter int NUM_MESSAGE = 10,
  parameter int BYTE_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MESSAGE-1:0] wr_index_i,
  output logic                   re_o,
  output logic                   read_start_o,
  output logic                   read_end_o,
  output logic [NUM_MESSAGE-1:0] read_index_o,
  input  logic [DATA_WIDTH-1:0]  start_i,
  input  logic [DATA_WIDTH-1:0]  end_i,
  output logic                   buf_re_o,
  output logic [DATA_WIDTH-1:0]  buf_raddr_o,
  input  logic [BYTE_WIDTH-1:0]  buf_data_i,
  output logic [BYTE_WIDTH-1:0]  data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   sop_o,
  output logic                   eop_o,
  output logic                   busy_o
);

  typedef enum logic [2:0] {
    IDLE, LOC_START, LOC_END, LOC_CAP, FETCH, CAPTURE, SEND
  } state_e;

  localparam logic [NUM_MESSAGE-1:0] LAST_IDX = NUM_MESSAGE'(NUM_MESSAGE - 1);

  state_e                 state_q;
  logic [NUM_MESSAGE-1:0] rd_idx_q, rd_idx_d;
  logic [DATA_WIDTH-1:0]  ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]  end_ptr_q;
  logic [BYTE_WIDTH-1:0]  data_q;
  logic                   first_q, sop_q, eop_q, valid_q;
  logic                   re_q, read_start_q, read_end_q, buf_re_q;

  // Index wraps at NUM_MESSAGE, the buffer pointer wraps naturally at 2^DATA_WIDTH.
  always_comb begin
    rd_idx_d = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + NUM_MESSAGE'(1);
    ptr_d    = ptr_q + DATA_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_idx_q     <= '0;
      ptr_q        <= '0;
      end_ptr_q    <= '0;
      data_q       <= '0;
      first_q      <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      valid_q      <= 1'b0;
      re_q         <= 1'b0;
      read_start_q <= 1'b0;
      read_end_q   <= 1'b0;
      buf_re_q     <= 1'b0;
    end else begin
      re_q         <= 1'b0;
      read_start_q <= 1'b0;
      read_end_q   <= 1'b0;
      buf_re_q     <= 1'b0;
      // Strobes are registered, so each is raised on the edge entering its state.
      case (state_q)
        IDLE: begin
          if (rd_idx_q != wr_index_i) begin
            state_q      <= LOC_START;
            re_q         <= 1'b1;
            read_start_q <= 1'b1;
          end
        end
        LOC_START: begin
          state_q    <= LOC_END;
          re_q       <= 1'b1;
          read_end_q <= 1'b1;
        end
        LOC_END: begin
          ptr_q   <= start_i;
          state_q <= LOC_CAP;
        end
        LOC_CAP: begin
          end_ptr_q <= end_i;
          first_q   <= 1'b1;
          buf_re_q  <= 1'b1;
          state_q   <= FETCH;
        end
        FETCH: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          data_q  <= buf_data_i;
          sop_q   <= first_q;
          eop_q   <= (ptr_q == end_ptr_q);
          valid_q <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            if (eop_q) begin
              rd_idx_q <= rd_idx_d;
              state_q  <= IDLE;
            end else begin
              first_q  <= 1'b0;
              ptr_q    <= ptr_d;
              buf_re_q <= 1'b1;
              state_q  <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign re_o         = re_q;
  assign read_start_o = read_start_q;
  assign read_end_o   = read_end_q;
  assign read_index_o = rd_idx_q;
  assign buf_re_o     = buf_re_q;
  assign buf_raddr_o  = ptr_q;
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign sop_o        = sop_q;
  assign eop_o        = eop_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_message_loc_reader.sv
// Directed bench for message_loc_reader with behavioural location table
// and message buffer models answering one cycle after each read.
module tb_message_loc_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] wr_index_i;
  logic       re_o, read_start_o, read_end_o;
  logic [9:0] read_index_o;
  logic [4:0] start_i, end_i;
  logic       buf_re_o;
  logic [4:0] buf_raddr_o;
  logic [7:0] buf_data_i;
  logic [7:0] data_o;
  logic       valid_o, ready_i, sop_o, eop_o, busy_o;

  logic [4:0] startTab [16];
  logic [4:0] endTab [16];
  logic [7:0] mem [32];

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  message_loc_reader #(.DATA_WIDTH(5), .NUM_MESSAGE(10), .BYTE_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .wr_index_i(wr_index_i),
    .re_o(re_o), .read_start_o(read_start_o), .read_end_o(read_end_o),
    .read_index_o(read_index_o), .start_i(start_i), .end_i(end_i),
    .buf_re_o(buf_re_o), .buf_raddr_o(buf_raddr_o), .buf_data_i(buf_data_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .sop_o(sop_o), .eop_o(eop_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Table and buffer return data on the edge after the corresponding read strobe.
  always @(posedge clk) begin
    if (re_o && read_start_o) start_i <= startTab[read_index_o[3:0]];
    if (re_o && read_end_o)   end_i   <= endTab[read_index_o[3:0]];
    if (buf_re_o)             buf_data_i <= mem[buf_raddr_o];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] wr, input logic rdy);
    wr_index_i = wr;
    ready_i    = rdy;
  endtask

  // Waits (bounded) for valid_o, sampling on falling edges.
  task automatic getByte(output logic [7:0] d, output logic s, output logic e, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!valid_o && cyc < 40);
    d = data_o;
    s = sop_o;
    e = eop_o;
  endtask

  logic [7:0] d;
  logic       s, e;
  int         cyc, bad;
  logic [7:0] expBytes [4];

  initial begin
    for (int i = 0; i < 16; i++) begin startTab[i] = '0; endTab[i] = '0; end
    for (int i = 0; i < 32; i++) mem[i] = 8'hFF;
    start_i = '0; end_i = '0; buf_data_i = '0;
    rst = 1'b1;
    applyStimulus(10'd0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 32'(valid_o), 0);
    checkOutput("rst_busy", 32'(busy_o), 0);
    checkOutput("rst_strobes", 32'({re_o, read_start_o, read_end_o, buf_re_o}), 0);
    checkOutput("rst_data", 32'({data_o, sop_o, eop_o}), 0);
    checkOutput("rst_index", 32'(read_index_o), 0);
    rst = 1'b0;

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_o || re_o || buf_re_o) bad++;
    end
    checkOutput("idle_quiet", 32'(bad), 0);

    // Basic message: entry 0 spans addresses 3..6.
    startTab[0] = 5'd3; endTab[0] = 5'd6;
    mem[3] = 8'hA0; mem[4] = 8'hA1; mem[5] = 8'hA2; mem[6] = 8'hA3;
    applyStimulus(10'd1, 1'b1);
    @(negedge clk);
    checkOutput("c1_locstart", 32'({re_o, read_start_o, read_end_o, busy_o}), 32'b1101);
    checkOutput("c1_index", 32'(read_index_o), 0);
    @(negedge clk);
    checkOutput("c2_locend", 32'({re_o, read_start_o, read_end_o}), 32'b101);
    @(negedge clk);
    checkOutput("c3_loccap", 32'({re_o, buf_re_o, valid_o}), 0);
    @(negedge clk);
    checkOutput("c4_fetch", 32'({buf_re_o, buf_raddr_o}), 32'({1'b1, 5'd3}));
    @(negedge clk);
    checkOutput("c5_capture", 32'({buf_re_o, valid_o}), 0);
    @(negedge clk);
    checkOutput("c6_first", 32'({valid_o, data_o, sop_o, eop_o}), 32'({1'b1, 8'hA0, 2'b10}));
    expBytes[1] = 8'hA1; expBytes[2] = 8'hA2; expBytes[3] = 8'hA3;
    for (int i = 1; i < 4; i++) begin
      getByte(d, s, e, cyc);
      checkOutput($sformatf("basic_byte%0d", i), 32'({valid_o, d, s, e}),
                  32'({1'b1, expBytes[i], 1'b0, (i == 3)}));
      checkOutput($sformatf("basic_gap%0d", i), 32'(cyc), 3);
    end
    @(negedge clk);
    checkOutput("basic_done", 32'({busy_o, valid_o, read_index_o}), 32'({2'b00, 10'd1}));

    // Wrap through address 0: entry 1 spans 30,31,0,1.
    startTab[1] = 5'd30; endTab[1] = 5'd1;
    mem[30] = 8'hB0; mem[31] = 8'hB1; mem[0] = 8'hB2; mem[1] = 8'hB3;
    expBytes[0] = 8'hB0; expBytes[1] = 8'hB1; expBytes[2] = 8'hB2; expBytes[3] = 8'hB3;
    applyStimulus(10'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      getByte(d, s, e, cyc);
      checkOutput($sformatf("wrap_byte%0d", i), 32'({valid_o, d, s, e}),
                  32'({1'b1, expBytes[i], (i == 0), (i == 3)}));
    end
    @(negedge clk);
    checkOutput("wrap_done", 32'({busy_o, read_index_o}), 32'({1'b0, 10'd2}));

    // Single byte held off by backpressure for 5 cycles.
    startTab[2] = 5'd7; endTab[2] = 5'd7; mem[7] = 8'hC7;
    applyStimulus(10'd3, 1'b0);
    getByte(d, s, e, cyc);
    checkOutput("single_first", 32'({valid_o, d, s, e}), 32'({1'b1, 8'hC7, 2'b11}));
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!valid_o || data_o !== 8'hC7 || !sop_o || !eop_o) bad++;
    end
    checkOutput("single_hold", 32'(bad), 0);
    @(negedge clk);
    checkOutput("single_sixth", 32'({valid_o, data_o}), 32'({1'b1, 8'hC7}));
    applyStimulus(10'd3, 1'b1);
    @(negedge clk);
    checkOutput("single_done", 32'({valid_o, busy_o, read_index_o}), 32'({2'b00, 10'd3}));

    // Drain entries 3..8 (single bytes at 23..28), then read entry 9 and wrap to 0.
    for (int k = 3; k < 9; k++) begin
      startTab[k] = 5'(k + 20); endTab[k] = 5'(k + 20); mem[k + 20] = 8'(8'hE0 + k);
    end
    startTab[9] = 5'd10; endTab[9] = 5'd11; mem[10] = 8'hD0; mem[11] = 8'hD1;
    applyStimulus(10'd9, 1'b1);
    bad = 0;
    for (int k = 3; k < 9; k++) begin
      getByte(d, s, e, cyc);
      if (!valid_o || d !== 8'(8'hE0 + k) || !s || !e) bad++;
    end
    checkOutput("drain_bytes", 32'(bad), 0);
    repeat (2) @(negedge clk);
    checkOutput("drain_at9", 32'({busy_o, read_index_o}), 32'({1'b0, 10'd9}));
    applyStimulus(10'd0, 1'b1);
    getByte(d, s, e, cyc);
    checkOutput("idx9_byte0", 32'({valid_o, d, s, e}), 32'({1'b1, 8'hD0, 2'b10}));
    getByte(d, s, e, cyc);
    checkOutput("idx9_byte1", 32'({valid_o, d, s, e}), 32'({1'b1, 8'hD1, 2'b01}));
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy_o || re_o || read_index_o !== 10'd0) bad++;
    end
    checkOutput("idx_wrapped_idle", 32'(bad), 0);

    // Reset while byte 2 of entry 0 is being offered; the message restarts from scratch.
    applyStimulus(10'd1, 1'b1);
    getByte(d, s, e, cyc);
    checkOutput("mid_byte0", 32'({valid_o, d}), 32'({1'b1, 8'hA0}));
    getByte(d, s, e, cyc);
    checkOutput("mid_byte1", 32'({valid_o, d}), 32'({1'b1, 8'hA1}));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset", 32'({valid_o, busy_o, read_index_o, data_o}), 0);
    rst = 1'b0;
    getByte(d, s, e, cyc);
    checkOutput("reread_latency", 32'(cyc), 6);
    checkOutput("reread_byte0", 32'({valid_o, d, s, e}), 32'({1'b1, 8'hA0, 2'b10}));
    for (int i = 1; i < 4; i++) getByte(d, s, e, cyc);
    checkOutput("reread_last", 32'({valid_o, d, e}), 32'({1'b1, 8'hA3, 1'b1}));
    @(negedge clk);
    checkOutput("reread_done", 32'({busy_o, read_index_o}), 32'({1'b0, 10'd1}));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
